// File: rtl/auto_test_sequencer.sv
// auto_test_sequencer: walks an N-bit vector 0..2^N-1 into a decoder under test.
// Each vector is held for DIV cycles, then the 2^N-bit response is checked
// against the one-hot value (1 << vector). The run stops on the first mismatch.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     level-sampled run request (honoured in IDLE, DONE and FAIL)
//   dec_out   decoder response, 2^N bits
//   test_in   vector driven to the decoder, N bits
//   tick      one-cycle strobe in the last cycle of each hold period
//   busy      run in progress
//   pass      sticky: all vectors matched
//   fail      sticky: run stopped on a mismatch
//   fail_vec  vector at which the first mismatch occurred
module auto_test_sequencer #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned N   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [(1<<N)-1:0]   dec_out,
  output logic [N-1:0]        test_in,
  output logic                tick,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic [N-1:0]        fail_vec
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [N-1:0]  VEC_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [N-1:0]  fvec_q, fvec_d;
  logic          tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      fvec_q  <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      fvec_q  <= fvec_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    fvec_d  = fvec_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    fail_d  = fail_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
          vec_d   = '0;
          fvec_d  = '0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        // Counter parks at DIV-1 through CHECK; it is cleared on the next vector.
        if (cnt_q == CNT_MAX) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        if (dec_out == (W'(1) << vec_q)) begin
          if (vec_q == VEC_MAX) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DRIVE;
            vec_d   = vec_q + N'(1);
            cnt_d   = '0;
          end
        end else begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          fvec_d  = vec_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered strobe: high in the cycle where the held count reads DIV-1.
    tick_d = (state_d == S_DRIVE) && (cnt_d == CNT_MAX);
  end

  assign test_in  = vec_q;
  assign tick     = tick_q;
  assign busy     = busy_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign fail_vec = fvec_q;

endmodule

// File: tb/tb_auto_test_sequencer.sv
// Scoreboard bench for auto_test_sequencer (DIV=4, N=3) with a behavioural decoder.
module tb_auto_test_sequencer;

  localparam int DIV = 4;
  localparam int N   = 3;
  localparam int W   = 1 << N;
  localparam int PER = DIV + 1;

  typedef struct {
    bit         is_pass;
    logic [2:0] vec;
    int         lat;
    int         ticks;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dec_out;
  logic [N-1:0] test_in;
  logic         tick, busy, pass, fail;
  logic [N-1:0] fail_vec;

  bit           fault_en  = 1'b0;
  logic [2:0]   fault_vec = '0;
  logic [7:0]   fault_val = '0;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   tmo_req = 0;
  int   tmo_ack = 0;
  bit   first_start_test = 1'b1;
  bit   b2b = 1'b0;

  auto_test_sequencer #(.DIV(DIV), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dec_out(dec_out),
    .test_in(test_in), .tick(tick), .busy(busy), .pass(pass),
    .fail(fail), .fail_vec(fail_vec)
  );

  always #5 clk = ~clk;

  // Ideal decoder with one optional faulty response
  always_comb begin
    dec_out = W'(1) << test_in;
    if (fault_en && test_in == fault_vec) dec_out = fault_val;
  end

  // Outcome of a run from the vector-walk rules: first vector whose response is not one-hot-correct
  function automatic exp_t predict(bit fen, logic [2:0] fv, logic [7:0] fval);
    exp_t e;
    logic [7:0] good, resp;
    for (int v = 0; v < W; v++) begin
      good = 8'(1) << v;
      resp = (fen && 3'(v) == fv) ? fval : good;
      if (resp != good) begin
        e.is_pass = 1'b0; e.vec = 3'(v); e.lat = (v + 1) * PER; e.ticks = v + 1;
        return e;
      end
    end
    e.is_pass = 1'b1; e.vec = 3'd7; e.lat = W * PER; e.ticks = W;
    return e;
  endfunction

  // ---------------- monitor / checker ----------------
  int   k, tcount, samp, gcyc, last_pass_g;
  bit   in_run, busy_prev, have_last, pend_first, prev_pass_valid;
  exp_t e_cur, e_last;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    in_run = 0; busy_prev = 0; have_last = 0; pend_first = 0;
    samp = 0; gcyc = 0; prev_pass_valid = 0; last_pass_g = 0;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (rst) begin
        chk("rst_test_in", 32'(test_in), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_fail_vec", 32'(fail_vec), 0);
        in_run = 0; busy_prev = 0; have_last = 0; samp = 0;
        pend_first = first_start_test;
      end else begin
        samp++;
        gcyc++;
        if (tmo_req != tmo_ack) begin
          n_cmp++; n_fail++;
          $display("FAIL stimulus_wait: run did not complete within budget");
          tmo_ack = tmo_req;
        end
        if (pend_first && samp == 2) begin
          chk("first_edge_start", 32'(busy), 1);
          pend_first = 0;
        end
        chk("pass_and_fail", 32'(pass & fail), 0);
        chk("tick_outside_run", 32'(tick & ~busy), 0);
        if (!b2b) prev_pass_valid = 0;

        if (busy && !busy_prev) begin
          in_run = 1; k = 0; tcount = 0;
        end else if (in_run) begin
          k++;
        end

        if (in_run) begin
          if (tick) tcount++;
          if (pass || fail) begin
            in_run = 0;
            done_cnt++;
            if (exp_q.size() == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL unexpected_end: pass=%0b fail=%0b with no expectation", pass, fail);
            end else begin
              e_cur = exp_q.pop_front();
              chk("end_pass", 32'(pass), 32'(e_cur.is_pass));
              chk("end_fail", 32'(fail), 32'(!e_cur.is_pass));
              chk("end_fail_vec", 32'(fail_vec), e_cur.is_pass ? 0 : 32'(e_cur.vec));
              chk("end_test_in", 32'(test_in), 32'(e_cur.vec));
              chk("end_busy", 32'(busy), 0);
              chk("end_latency", 32'(k), 32'(e_cur.lat));
              chk("tick_count", 32'(tcount), 32'(e_cur.ticks));
              if (b2b && pass) begin
                if (prev_pass_valid) chk("b2b_period", 32'(gcyc - last_pass_g), 32'(W * PER + 1));
                prev_pass_valid = 1;
                last_pass_g = gcyc;
              end
              e_last = e_cur;
              have_last = 1;
            end
          end else begin
            chk("tick", 32'(tick), 32'((k % PER) == DIV - 1));
            chk("test_in", 32'(test_in), 32'(k / PER));
            chk("busy", 32'(busy), 1);
            if (k > (W + 1) * PER) begin
              n_cmp++; n_fail++;
              $display("FAIL run_timeout: no pass/fail after %0d cycles", k);
              in_run = 0;
              done_cnt++;
            end
          end
        end else if (have_last) begin
          chk("hold_pass", 32'(pass), 32'(e_last.is_pass));
          chk("hold_fail", 32'(fail), 32'(!e_last.is_pass));
          chk("hold_test_in", 32'(test_in), 32'(e_last.vec));
          chk("hold_fail_vec", 32'(fail_vec), e_last.is_pass ? 0 : 32'(e_last.vec));
        end
        busy_prev = busy;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) @(posedge clk);
    if (done_cnt < target) tmo_req++;
  endtask

  task automatic do_run(bit fen, logic [2:0] fv, logic [7:0] fval, bit jitter);
    exp_t e;
    int   target;
    e = predict(fen, fv, fval);
    fault_en = fen; fault_vec = fv; fault_val = fval;
    exp_q.push_back(e);
    target = done_cnt + 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (jitter) begin
      // start toggles during DRIVE/CHECK, released well before DONE/FAIL
      for (int i = 0; i < e.lat - 3; i++) begin
        @(negedge clk); start = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
    end
    wait_done(target);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    exp_t e;
    int   target;
    bit         fen;
    logic [2:0] fv;
    logic [7:0] fval;

    repeat (3) @(negedge clk);
    // start already high on the first edge after reset release
    e = predict(1'b0, 3'd0, 8'h00);
    exp_q.push_back(e);
    target = done_cnt + 1;
    rst = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(target);
    first_start_test = 1'b0;
    repeat (3) @(negedge clk);

    do_run(1'b1, 3'd5, 8'h00, 1'b0);
    do_run(1'b1, 3'd0, 8'h03, 1'b0);

    // asynchronous reset while vector 3 is driven
    fault_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 100 && test_in != 3'd3; i++) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    do_run(1'b0, 3'd0, 8'h00, 1'b0);

    for (int r = 0; r < 12; r++) begin
      fen  = ($urandom_range(0, 3) != 0);
      fv   = 3'($urandom_range(0, 7));
      fval = ($urandom_range(0, 3) == 0) ? (8'(1) << fv) : 8'($urandom);
      do_run(fen, fv, fval, 1'b1);
    end

    // start held high across three ideal runs
    fault_en = 1'b0;
    b2b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = predict(1'b0, 3'd0, 8'h00);
      exp_q.push_back(e);
    end
    target = done_cnt + 3;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 400 && done_cnt < target - 1; i++) @(posedge clk);
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_done(target);
    repeat (3) @(negedge clk);
    b2b = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
